// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port MemReadWrite between fetch (F), data (D)
// and inference readout (I). Presents a req/gnt/ack handshake and hides the
// fixed memory read latency. Every output comes straight from a register.
module mem_port_arbiter #(
  parameter int unsigned READ_LAT   = 3,     // 1..7
  parameter int unsigned INFER_BASE = 6300,
  parameter int unsigned STARVE_LIM = 4      // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_f,
  input  logic [15:0] addr_f,
  input  logic        req_d,
  input  logic        we_d,
  input  logic [15:0] addr_d,
  input  logic [31:0] wdata_d,
  input  logic        req_i,
  input  logic [9:0]  addr_i,
  output logic        gnt_f,
  output logic        gnt_d,
  output logic        gnt_i,
  output logic        ack_f,
  output logic        ack_d,
  output logic        ack_i,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {PORT_F, PORT_D, PORT_I} port_t;

  localparam logic [2:0]  LAST_CNT  = 3'(READ_LAT - 1);
  localparam logic [3:0]  LIM       = 4'(STARVE_LIM);
  localparam logic [15:0] BASE16    = 16'(INFER_BASE);

  state_t      state, state_nxt;
  port_t       port, port_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [3:0]  starve, starve_nxt;

  logic        gnt_f_nxt, gnt_d_nxt, gnt_i_nxt;
  logic        ack_f_nxt, ack_d_nxt, ack_i_nxt;
  logic [31:0] rdata_nxt;
  logic        mem_en_nxt, mem_ren_nxt, mem_wen_nxt;
  logic [15:0] mem_addr_nxt;
  logic [31:0] mem_din_nxt;

  // Inference index mapped into the memory map; the 16-bit add wraps mod 65536.
  logic [15:0] infer_addr;
  assign infer_addr = {6'd0, addr_i} + BASE16;

  // Arbitration winner: I jumps the queue once it has starved long enough.
  logic pick_i, pick_d, pick_f;
  assign pick_i = req_i && ((starve == LIM) || (!req_d && !req_f));
  assign pick_d = !pick_i && req_d;
  assign pick_f = !pick_i && !req_d && req_f;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_nxt    = state;
    port_nxt     = port;
    cnt_nxt      = cnt;
    starve_nxt   = starve;
    gnt_f_nxt    = 1'b0;
    gnt_d_nxt    = 1'b0;
    gnt_i_nxt    = 1'b0;
    ack_f_nxt    = 1'b0;
    ack_d_nxt    = 1'b0;
    ack_i_nxt    = 1'b0;
    rdata_nxt    = rdata;
    mem_en_nxt   = 1'b0;
    mem_ren_nxt  = 1'b0;
    mem_wen_nxt  = 1'b0;
    mem_addr_nxt = 16'd0;
    mem_din_nxt  = 32'd0;

    unique case (state)
      IDLE: begin
        if (pick_i || pick_d || pick_f) begin
          cnt_nxt    = 3'd0;
          mem_en_nxt = 1'b1;
          if (pick_i) begin
            starve_nxt   = 4'd0;
            port_nxt     = PORT_I;
            gnt_i_nxt    = 1'b1;
            mem_ren_nxt  = 1'b1;
            mem_addr_nxt = infer_addr;
            state_nxt    = READ;
          end else begin
            // I lost this round while asking: one step closer to top priority.
            if (req_i && starve != LIM) starve_nxt = starve + 4'd1;
            if (pick_d) begin
              port_nxt     = PORT_D;
              gnt_d_nxt    = 1'b1;
              mem_addr_nxt = addr_d;
              if (we_d) begin
                mem_wen_nxt = 1'b1;
                mem_din_nxt = wdata_d;
                state_nxt   = WRITE;
              end else begin
                mem_ren_nxt = 1'b1;
                state_nxt   = READ;
              end
            end else begin
              port_nxt     = PORT_F;
              gnt_f_nxt    = 1'b1;
              mem_ren_nxt  = 1'b1;
              mem_addr_nxt = addr_f;
              state_nxt    = READ;
            end
          end
        end
      end
      READ: begin
        if (cnt == LAST_CNT) begin
          rdata_nxt = mem_dout;
          ack_f_nxt = (port == PORT_F);
          ack_d_nxt = (port == PORT_D);
          ack_i_nxt = (port == PORT_I);
          cnt_nxt   = 3'd0;
          state_nxt = DONE;
        end else begin
          cnt_nxt      = cnt + 3'd1;
          mem_en_nxt   = 1'b1;
          mem_ren_nxt  = 1'b1;
          mem_addr_nxt = mem_addr;
        end
      end
      WRITE: begin
        ack_d_nxt = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    if (!reset) begin
      state    <= IDLE;
      port     <= PORT_F;
      cnt      <= 3'd0;
      starve   <= 4'd0;
      gnt_f    <= 1'b0;
      gnt_d    <= 1'b0;
      gnt_i    <= 1'b0;
      ack_f    <= 1'b0;
      ack_d    <= 1'b0;
      ack_i    <= 1'b0;
      rdata    <= 32'd0;
      busy     <= 1'b0;
      mem_en   <= 1'b0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= 16'd0;
      mem_din  <= 32'd0;
    end else begin
      state    <= state_nxt;
      port     <= port_nxt;
      cnt      <= cnt_nxt;
      starve   <= starve_nxt;
      gnt_f    <= gnt_f_nxt;
      gnt_d    <= gnt_d_nxt;
      gnt_i    <= gnt_i_nxt;
      ack_f    <= ack_f_nxt;
      ack_d    <= ack_d_nxt;
      ack_i    <= ack_i_nxt;
      rdata    <= rdata_nxt;
      busy     <= (state_nxt != IDLE);
      mem_en   <= mem_en_nxt;
      mem_ren  <= mem_ren_nxt;
      mem_wen  <= mem_wen_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default build (READ_LAT=3) backed by
// a word-array memory, and a READ_LAT=1 / INFER_BASE=65000 build backed by a
// combinational address-echo memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: default parameters
  logic        reset;
  logic        a_req_f, a_req_d, a_we_d, a_req_i;
  logic [15:0] a_addr_f, a_addr_d;
  logic [31:0] a_wdata_d;
  logic [9:0]  a_addr_i;
  logic        a_gnt_f, a_gnt_d, a_gnt_i, a_ack_f, a_ack_d, a_ack_i;
  logic [31:0] a_rdata, a_mem_din, a_mem_dout;
  logic        a_busy, a_mem_en, a_mem_ren, a_mem_wen;
  logic [15:0] a_mem_addr;

  // Instance B: READ_LAT=1, INFER_BASE=65000
  logic        b_req_f, b_req_d, b_we_d, b_req_i;
  logic [15:0] b_addr_f, b_addr_d;
  logic [31:0] b_wdata_d;
  logic [9:0]  b_addr_i;
  logic        b_gnt_f, b_gnt_d, b_gnt_i, b_ack_f, b_ack_d, b_ack_i;
  logic [31:0] b_rdata, b_mem_din, b_mem_dout;
  logic        b_busy, b_mem_en, b_mem_ren, b_mem_wen;
  logic [15:0] b_mem_addr;

  mem_port_arbiter dut_a (
    .clk(clk), .reset(reset),
    .req_f(a_req_f), .addr_f(a_addr_f),
    .req_d(a_req_d), .we_d(a_we_d), .addr_d(a_addr_d), .wdata_d(a_wdata_d),
    .req_i(a_req_i), .addr_i(a_addr_i),
    .gnt_f(a_gnt_f), .gnt_d(a_gnt_d), .gnt_i(a_gnt_i),
    .ack_f(a_ack_f), .ack_d(a_ack_d), .ack_i(a_ack_i),
    .rdata(a_rdata), .busy(a_busy),
    .mem_en(a_mem_en), .mem_ren(a_mem_ren), .mem_wen(a_mem_wen),
    .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_dout(a_mem_dout)
  );

  mem_port_arbiter #(.READ_LAT(1), .INFER_BASE(65000), .STARVE_LIM(4)) dut_b (
    .clk(clk), .reset(reset),
    .req_f(b_req_f), .addr_f(b_addr_f),
    .req_d(b_req_d), .we_d(b_we_d), .addr_d(b_addr_d), .wdata_d(b_wdata_d),
    .req_i(b_req_i), .addr_i(b_addr_i),
    .gnt_f(b_gnt_f), .gnt_d(b_gnt_d), .gnt_i(b_gnt_i),
    .ack_f(b_ack_f), .ack_d(b_ack_d), .ack_i(b_ack_i),
    .rdata(b_rdata), .busy(b_busy),
    .mem_en(b_mem_en), .mem_ren(b_mem_ren), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
  );

  // Memory model for A: registered read, data is stable well before READ_LAT.
  logic [31:0] a_mem [0:65535];
  always @(posedge clk) begin
    if (a_mem_en && a_mem_wen) a_mem[a_mem_addr] <= a_mem_din;
    if (a_mem_en && a_mem_ren) a_mem_dout <= a_mem[a_mem_addr];
  end

  // Memory model for B: data valid within the same cycle as the address.
  assign b_mem_dout = (b_mem_en && b_mem_ren) ? {16'hB000, b_mem_addr} : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; observe and drive at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run A until idle, collecting which ack ports pulsed; bounded.
  task automatic a_wait_done(output logic [2:0] acks);
    acks = 3'b000;
    for (int k = 0; k < 20 && a_busy; k++) begin
      tick();
      acks |= {a_ack_i, a_ack_d, a_ack_f};
    end
    check("a idle reached", {31'd0, a_busy}, 32'd0);
  endtask

  // Edges from accept to first ack on A; bounded at 20.
  task automatic a_ack_latency(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(a_ack_f || a_ack_d || a_ack_i) && n < 20);
  endtask

  logic [2:0] acks;
  logic [2:0] exp_gnt;
  int         lat;
  logic       seen;

  initial begin
    a_mem[16'h0010] = 32'h2002000A;
    a_mem_dout = 32'h0;
    reset = 1'b0;
    {a_req_f, a_req_d, a_we_d, a_req_i} = '0;
    {b_req_f, b_req_d, b_we_d, b_req_i} = '0;
    a_addr_f = '0; a_addr_d = '0; a_wdata_d = '0; a_addr_i = '0;
    b_addr_f = '0; b_addr_d = '0; b_wdata_d = '0; b_addr_i = '0;
    tick();
    tick();
    check("reset rdata", a_rdata, 32'h0);
    check("reset mem_addr", {16'd0, a_mem_addr}, 32'h0);
    check("reset ctl", {a_busy, a_mem_en, a_gnt_f, a_gnt_d, a_gnt_i, a_ack_f, a_ack_d, a_ack_i}, 32'h0);
    reset = 1'b1;
    tick();

    // 1: lone fetch read
    a_req_f = 1'b1; a_addr_f = 16'h0010;
    tick();
    a_req_f = 1'b0;
    check("t1 gnt_f", {a_gnt_f, a_gnt_d, a_gnt_i}, 32'b100);
    check("t1 mem ctl", {a_mem_en, a_mem_ren, a_mem_wen, a_busy}, 32'b1101);
    check("t1 mem_addr", {16'd0, a_mem_addr}, 32'h0010);
    tick();
    check("t1 E1 gnt/ack", {a_gnt_f, a_ack_f, a_mem_en}, 32'b001);
    tick();
    check("t1 E2 ack", {a_ack_f, a_mem_en, a_mem_addr}, {15'd0, 1'b0, 1'b1, 16'h0010});
    tick();
    check("t1 E3 ack_f", {a_ack_f, a_mem_en, a_busy}, 32'b101);
    check("t1 rdata", a_rdata, 32'h2002000A);
    tick();
    check("t1 E4 idle", {a_ack_f, a_busy}, 32'b00);

    // 2: store then load
    a_req_d = 1'b1; a_we_d = 1'b1; a_addr_d = 16'h0100; a_wdata_d = 32'hDEADBEEF;
    tick();
    a_req_d = 1'b0;
    check("t2 st gnt_d", {a_gnt_f, a_gnt_d, a_gnt_i}, 32'b010);
    check("t2 st mem ctl", {a_mem_en, a_mem_ren, a_mem_wen}, 32'b101);
    check("t2 st mem_din", a_mem_din, 32'hDEADBEEF);
    check("t2 st mem_addr", {16'd0, a_mem_addr}, 32'h0100);
    tick();
    check("t2 st ack/wen", {a_ack_d, a_mem_wen, a_mem_en}, 32'b100);
    check("t2 st rdata kept", a_rdata, 32'h2002000A);
    tick();
    check("t2 st idle", {31'd0, a_busy}, 32'd0);
    a_req_d = 1'b1; a_we_d = 1'b0;
    tick();
    a_req_d = 1'b0;
    check("t2 ld gnt_d", {a_gnt_f, a_gnt_d, a_gnt_i}, 32'b010);
    a_ack_latency(lat);
    check("t2 ld latency", lat, 3);
    check("t2 ld ack_d", {a_ack_f, a_ack_d, a_ack_i}, 32'b010);
    check("t2 ld rdata", a_rdata, 32'hDEADBEEF);
    a_wait_done(acks);

    // 3: contention with I always asking; D present on alternate rounds
    a_addr_f = 16'h0010; a_addr_d = 16'h0100; a_addr_i = 10'd5;
    for (int r = 0; r < 6; r++) begin
      a_req_d = (r % 2 == 0); a_req_f = 1'b1; a_req_i = 1'b1;
      tick();
      {a_req_f, a_req_d, a_req_i} = 3'b000;
      exp_gnt = (r == 4) ? 3'b100 : ((r % 2 == 0) ? 3'b010 : 3'b001);
      check($sformatf("t3 r%0d gnt {i,d,f}", r), {a_gnt_i, a_gnt_d, a_gnt_f}, exp_gnt);
      if (r == 4) check("t3 I addr", {16'd0, a_mem_addr}, 32'd6305);
      a_wait_done(acks);
      check($sformatf("t3 r%0d ack {i,d,f}", r), acks, exp_gnt);
    end

    // 4: inference address mapping (A) and wrap (B)
    a_req_i = 1'b1; a_addr_i = 10'd1023;
    b_req_i = 1'b1; b_addr_i = 10'd600;
    tick();
    a_req_i = 1'b0; b_req_i = 1'b0;
    check("t4 a mem_addr", {16'd0, a_mem_addr}, 32'd7323);
    check("t4 b mem_addr", {16'd0, b_mem_addr}, 32'd64);
    check("t4 b gnt_i", {b_gnt_i, b_gnt_d, b_gnt_f}, 32'b100);
    tick();
    check("t6 b ack_i 1 edge", {b_ack_i, b_ack_d, b_ack_f}, 32'b100);
    check("t6 b rdata", b_rdata, 32'hB0000040);
    a_wait_done(acks);
    check("t4 a ack_i", acks, 3'b100);

    // 6: B with req_f held through gnt issues a second access
    tick();
    check("t6 b idle", {31'd0, b_busy}, 32'd0);
    b_req_f = 1'b1; b_addr_f = 16'h0077;
    tick();
    check("t6 b gnt_f #1", {31'd0, b_gnt_f}, 32'd1);
    tick();
    check("t6 b ack_f", {b_ack_f, b_gnt_f}, 32'b10);
    check("t6 b rdata f", b_rdata, 32'hB0000077);
    tick();
    check("t6 b done no gnt", {31'd0, b_gnt_f}, 32'd0);
    tick();
    b_req_f = 1'b0;
    check("t6 b gnt_f #2", {31'd0, b_gnt_f}, 32'd1);
    tick();
    tick();

    // 5: reset one cycle after a read accept aborts it
    a_req_f = 1'b1; a_addr_f = 16'h0010;
    tick();
    a_req_f = 1'b0;
    check("t5 gnt_f", {31'd0, a_gnt_f}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5 abort ctl", {a_mem_en, a_mem_ren, a_busy, a_gnt_f, a_ack_f}, 32'b0);
    check("t5 abort rdata", a_rdata, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen |= a_ack_f;
    end
    check("t5 no stale ack_f", {31'd0, seen}, 32'd0);
    a_req_f = 1'b1;
    tick();
    a_req_f = 1'b0;
    check("t5 fresh gnt_f", {31'd0, a_gnt_f}, 32'd1);
    a_ack_latency(lat);
    check("t5 fresh latency", lat, 3);
    check("t5 fresh rdata", a_rdata, 32'h2002000A);
    a_wait_done(acks);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
